atmega_pcint: RTL and testbench

//  Pin-input front end and pin-change interrupt unit for one 8-bit ATmega port.

---
 rtl/atmega_pcint_pkg.sv | 9 +
 rtl/atmega_pcint_sync.sv | 51 +++++
 rtl/atmega_pcint.sv | 68 ++++++
 tb/tb_atmega_pcint.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/atmega_pcint_pkg.sv
// Shared constants for the ATmega pin-change interrupt unit: default register
// addresses and the bit positions of PCIE (in PCICR) and PCIF (in PCIFR).
package atmega_pcint_pkg;
    localparam int PCICR_ADDR_DEF = 'h68;
    localparam int PCIFR_ADDR_DEF = 'h3B;
    localparam int PCMSK_ADDR_DEF = 'h6B;
    localparam int PCIE_BIT       = 0;
    localparam int PCIF_BIT       = 0;
endpackage

// File: rtl/atmega_pcint_sync.sv
// Two-flop pad synchroniser with an optional one-cycle glitch filter
// (enabled by `ATMEGA_PCINT_FILTER_EN); outputs the current and previous sample.
module atmega_pcint_sync #(
    parameter int           W       = 8,
    parameter logic [W-1:0] PINMASK = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pin_raw,
    output logic [W-1:0] pin_sync,
    output logic [W-1:0] pin_prev
);
    logic [W-1:0] s1, s2, s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin_raw & PINMASK;
            s2 <= s1;
        end
    end

`ifdef ATMEGA_PCINT_FILTER_EN
    logic [W-1:0] f;

    // A bit of s2 is accepted once the following sample (s1) agrees with it,
    // so a value must persist two synchronised cycles; single-cycle pulses never land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f  <= '0;
            s3 <= '0;
        end else begin
            f  <= (s2 & ~(s1 ^ s2)) | (f & (s1 ^ s2));
            s3 <= f;
        end
    end

    assign pin_sync = f;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s3 <= '0;
        else      s3 <= s2;
    end

    assign pin_sync = s2;
`endif

    assign pin_prev = s3;
endmodule

// File: rtl/atmega_pcint.sv
// Pin-change interrupt unit for one 8-bit port: PCICR/PCIFR/PCMSK registers,
// change detection and interrupt request. `ATMEGA_PCINT_FILTER_EN adds a glitch filter.
module atmega_pcint
    import atmega_pcint_pkg::*;
#(
    parameter int                           BUS_ADDR_DATA_LEN = 16,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCICR_ADDR        = BUS_ADDR_DATA_LEN'(PCICR_ADDR_DEF),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIFR_ADDR        = BUS_ADDR_DATA_LEN'(PCIFR_ADDR_DEF),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR        = BUS_ADDR_DATA_LEN'(PCMSK_ADDR_DEF),
    parameter logic [7:0]                   PINMASK           = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    input  logic [7:0]                   pin_raw,
    output logic [7:0]                   pin_sync,
    output logic                         int_req,
    input  logic                         int_ack
);
    logic [7:0] pin_prev;
    logic [7:0] pcmsk;
    logic [7:0] chg;
    logic       pcie, pcif;
    logic       wr_icr, wr_ifr, wr_msk, pcif_clr;

    atmega_pcint_sync #(.W(8), .PINMASK(PINMASK)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pin_raw  (pin_raw),
        .pin_sync (pin_sync),
        .pin_prev (pin_prev)
    );

    assign chg      = (pin_sync ^ pin_prev) & pcmsk & PINMASK;
    assign wr_icr   = wr && (addr == PCICR_ADDR);
    assign wr_ifr   = wr && (addr == PCIFR_ADDR);
    assign wr_msk   = wr && (addr == PCMSK_ADDR);
    assign pcif_clr = (wr_ifr && bus_in[PCIF_BIT]) || int_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcie  <= 1'b0;
            pcif  <= 1'b0;
            pcmsk <= 8'h00;
        end else begin
            if (wr_icr) pcie  <= bus_in[PCIE_BIT];
            if (wr_msk) pcmsk <= bus_in & PINMASK;
            // A change arriving with a clear must not be lost, so set has priority.
            if (|chg)          pcif <= 1'b1;
            else if (pcif_clr) pcif <= 1'b0;
        end
    end

    assign int_req = pcie & pcif;

    always_comb begin
        bus_out = 8'h00;
        if (rd && rst) begin
            if (addr == PCICR_ADDR)      bus_out[PCIE_BIT] = pcie;
            else if (addr == PCIFR_ADDR) bus_out[PCIF_BIT] = pcif;
            else if (addr == PCMSK_ADDR) bus_out = pcmsk;
        end
    end
endmodule

// File: tb/tb_atmega_pcint.sv
// Self-checking bench for atmega_pcint: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a delay-line behavioural model.
module tb_atmega_pcint;
    localparam logic [15:0] A_ICR = 16'h0068;
    localparam logic [15:0] A_IFR = 16'h003B;
    localparam logic [15:0] A_MSK = 16'h006B;
`ifdef ATMEGA_PCINT_FILTER_EN
    localparam int FD = 1;
`else
    localparam int FD = 0;
`endif

    logic        clk = 0, rst = 1, wr = 0, rd = 0, int_ack = 0;
    logic [15:0] addr = 0;
    logic [7:0]  bus_in = 0, pin_raw = 0;
    logic [7:0]  bus_out, pin_sync;
    logic        int_req;

    int checks = 0, errors = 0;

    atmega_pcint dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in),
        .bus_out(bus_out), .pin_raw(pin_raw), .pin_sync(pin_sync),
        .int_req(int_req), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // dl[k] = masked pad value as sampled k+1 edges ago (dl[0] is the newest sample).
    logic [7:0] dl[$];
    logic [7:0] m_msk = 0, mf = 0, mfp = 0;
    logic       m_pcie = 0, m_pcif = 0;

    initial dl = '{8'h00, 8'h00, 8'h00};

    function automatic logic [7:0] m_sync();
`ifdef ATMEGA_PCINT_FILTER_EN
        return mf;
`else
        return dl[1];
`endif
    endfunction

    function automatic logic [7:0] m_prev();
`ifdef ATMEGA_PCINT_FILTER_EN
        return mfp;
`else
        return dl[2];
`endif
    endfunction

    function automatic logic [7:0] m_bus();
        if (!(rd && rst)) return 8'h00;
        if (addr == A_ICR) return {7'b0, m_pcie};
        if (addr == A_IFR) return {7'b0, m_pcif};
        if (addr == A_MSK) return m_msk;
        return 8'h00;
    endfunction

    always @(posedge clk or negedge rst) begin : mdl
        logic [7:0] chg;
        logic       clr;
        if (!rst) begin
            dl = '{8'h00, 8'h00, 8'h00};
            mf = 0; mfp = 0; m_msk = 0; m_pcie = 0; m_pcif = 0;
        end else begin
            chg = (m_sync() ^ m_prev()) & m_msk;
            clr = (wr && addr == A_IFR && bus_in[0]) || int_ack;
            if (chg != 0) m_pcif = 1;
            else if (clr) m_pcif = 0;
            if (wr && addr == A_ICR) m_pcie = bus_in[0];
            if (wr && addr == A_MSK) m_msk = bus_in;
            mfp = mf;
            for (int b = 0; b < 8; b++)
                if (dl[0][b] == dl[1][b]) mf[b] = dl[1][b];
            dl.push_front(pin_raw);
            void'(dl.pop_back());
        end
    end

    // Outputs are compared against the model on every falling edge.
    always @(negedge clk) begin
        chk("pin_sync", pin_sync, m_sync());
        chk("int_req", {7'b0, int_req}, {7'b0, m_pcie & m_pcif});
        chk("bus_out", bus_out, m_bus());
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        addr = a; bus_in = d; wr = 1;
        tick();
        wr = 0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
        addr = a; rd = 1;
        #1 chk(nm, bus_out, exp);
        rd = 0;
    endtask

    initial begin
        // 1. reset with pads high
        #1 rst = 0;
        pin_raw = 8'hFF;
        repeat (3) tick();
        chk("rst_pin_sync", pin_sync, 8'h00);
        chk("rst_int_req", {7'b0, int_req}, 8'h00);
        rd_chk("rst_rd_icr", A_ICR, 8'h00);
        rst = 1;
        rd_chk("rst_rd_ifr", A_IFR, 8'h00);
        rd_chk("rst_rd_msk", A_MSK, 8'h00);
        pin_raw = 8'h00;
        repeat (5) tick();
        rd_chk("no_spurious_flag", A_IFR, 8'h00);

        // 2. basic change on pin 2
        wr_reg(A_MSK, 8'h04);
        wr_reg(A_ICR, 8'h01);
        rd_chk("rd_msk", A_MSK, 8'h04);
        pin_raw[2] = 1;
        tick();
        chk("sync_e0", pin_sync, 8'h00);
        repeat (FD) tick();
        tick();
        chk("sync_e1", pin_sync, 8'h04);
        chk("irq_e1", {7'b0, int_req}, 8'h00);
        tick();
        chk("irq_e2", {7'b0, int_req}, 8'h01);
        rd_chk("rd_ifr_set", A_IFR, 8'h01);

        // 4a. write-1-to-clear
        wr_reg(A_IFR, 8'h01);
        chk("w1c_irq", {7'b0, int_req}, 8'h00);
        rd_chk("w1c_ifr", A_IFR, 8'h00);

        // 3. masked pin follows but never flags
        pin_raw[3] = 1;
        repeat (5) tick();
        chk("masked_sync", pin_sync, 8'h0C);
        rd_chk("masked_ifr", A_IFR, 8'h00);

        // 4b. write 0 is no-op, int_ack clears
        pin_raw[2] = 0;
        repeat (5) tick();
        rd_chk("fall_flag", A_IFR, 8'h01);
        wr_reg(A_IFR, 8'h00);
        rd_chk("w0_keep", A_IFR, 8'h01);
        int_ack = 1; tick(); int_ack = 0;
        rd_chk("ack_clr", A_IFR, 8'h00);

        // 4c. ack in the same cycle as a change: set wins
        pin_raw[2] = 1;
        tick();
        repeat (FD) tick();
        tick();
        int_ack = 1; tick(); int_ack = 0;
        rd_chk("ack_vs_set", A_IFR, 8'h01);

        // 5. gating by PCIE
        wr_reg(A_ICR, 8'h00);
        chk("gate_off", {7'b0, int_req}, 8'h00);
        rd_chk("gate_keep_flag", A_IFR, 8'h01);
        wr_reg(A_ICR, 8'h01);
        chk("gate_on", {7'b0, int_req}, 8'h01);

        // unmasking a stable-high pin does not flag by itself
        wr_reg(A_IFR, 8'h01);
        wr_reg(A_MSK, 8'h0C);
        repeat (4) tick();
        rd_chk("unmask_noflag", A_IFR, 8'h00);

`ifdef ATMEGA_PCINT_FILTER_EN
        // 6. filter: 1-cycle pulse rejected, 3-cycle pulse flags at edge 3
        wr_reg(A_MSK, 8'h01);
        pin_raw[0] = 1; tick(); pin_raw[0] = 0;
        repeat (6) tick();
        rd_chk("filt_short", A_IFR, 8'h00);
        pin_raw[0] = 1;
        repeat (3) tick();
        pin_raw[0] = 0;
        rd_chk("filt_e2", A_IFR, 8'h00);
        tick();
        rd_chk("filt_e3", A_IFR, 8'h01);
        repeat (6) tick();
`endif

        // randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 5) == 0) pin_raw[$urandom_range(0, 7)] ^= 1'b1;
            wr = ($urandom_range(0, 3) == 0);
            rd = $urandom_range(0, 1) != 0;
            int_ack = ($urandom_range(0, 7) == 0);
            bus_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0: addr = A_ICR;
                1: addr = A_IFR;
                2: addr = A_MSK;
                default: addr = 16'($urandom);
            endcase
            tick();
        end
        wr = 0; rd = 0; int_ack = 0; rst = 1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
